// File: rtl/bcd_to_gray.sv
// bcd_to_gray: registered single-digit BCD to 4-bit reflected Gray converter.
//
// A digit on a..d is accepted on every rising clk edge where in_valid=1. The
// Gray code appears on e..h one cycle later, with out_valid pulsed for that
// cycle. Codes 1010..1111 are still converted with the same equations. When
// detection is built in, such codes are also flagged.
//
// Build option:
//   BCD_TO_GRAY_CHECK_EN - when defined, adds invalid-code detection
//                          (bcd_err, err_sticky, clr_err). When undefined,
//                          bcd_err and err_sticky are tied to 0 and clr_err
//                          is ignored.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   a,b,c,d    in   BCD digit, a = MSB, d = LSB
//   in_valid   in   qualifies a..d this cycle
//   clr_err    in   synchronous clear of err_sticky (set has priority)
//   e,f,g,h    out  Gray code, e = MSB, h = LSB; held while idle
//   out_valid  out  e..h carry a new result this cycle
//   bcd_err    out  the result on e..h came from a non-BCD input
//   err_sticky out  latched OR of bcd_err since the last clear or reset

module bcd_to_gray (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic in_valid,
  input  logic clr_err,
  output logic e,
  output logic f,
  output logic g,
  output logic h,
  output logic out_valid,
  output logic bcd_err,
  output logic err_sticky
);

  logic [3:0] gray_q, gray_d;
  logic       valid_q, valid_d;

  // Conversion path. The result register holds its value while idle.
  always_comb begin
    gray_d  = gray_q;
    valid_d = in_valid;
    if (in_valid) begin
      gray_d = {a, a ^ b, b ^ c, c ^ d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q  <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      gray_q  <= gray_d;
      valid_q <= valid_d;
    end
  end

  assign e         = gray_q[3];
  assign f         = gray_q[2];
  assign g         = gray_q[1];
  assign h         = gray_q[0];
  assign out_valid = valid_q;

`ifdef BCD_TO_GRAY_CHECK_EN
  logic [3:0] bcd;
  logic       err_q, err_d;
  logic       sticky_q, sticky_d;

  assign bcd = {a, b, c, d};

  // A new error sets the sticky flag even when clr_err is asserted on the same edge.
  always_comb begin
    err_d    = in_valid && (bcd >= 4'd10);
    sticky_d = sticky_q;
    if (err_d) begin
      sticky_d = 1'b1;
    end else if (clr_err) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign bcd_err    = err_q;
  assign err_sticky = sticky_q;
`else
  // Detection is not built in, so clr_err has no function.
  logic unused_clr_err;
  assign unused_clr_err = clr_err;

  assign bcd_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_gray.sv
// Testbench for bcd_to_gray. It applies directed and $urandom stimulus and
// compares every cycle against a reference model. The model computes Gray as
// x ^ (x >> 1) and applies the accept/hold/error rules directly.
// Build option: BCD_TO_GRAY_CHECK_EN, which must match the RTL build.

module tb_bcd_to_gray;

`ifdef BCD_TO_GRAY_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic in_valid = 1'b0;
  logic clr_err = 1'b0;
  logic e, f, g, h, out_valid, bcd_err, err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_gray   = 4'b0000;
  logic       m_valid  = 1'b0;
  logic       m_err    = 1'b0;
  logic       m_sticky = 1'b0;

  bcd_to_gray dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .in_valid   (in_valid),
    .clr_err    (clr_err),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .out_valid  (out_valid),
    .bcd_err    (bcd_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".gray"},   {4'b0, e, f, g, h}, {4'b0, m_gray});
    check_eq({tag, ".valid"},  {7'b0, out_valid},  {7'b0, m_valid});
    check_eq({tag, ".err"},    {7'b0, bcd_err},    {7'b0, m_err});
    check_eq({tag, ".sticky"}, {7'b0, err_sticky}, {7'b0, m_sticky});
  endtask

  // Drive one cycle, advance the model at the edge, then compare 1 ns later.
  task automatic step(input logic [3:0] x, input logic v, input logic clr, input string tag);
    {a, b, c, d} = x;
    in_valid = v;
    clr_err  = clr;
    @(posedge clk);
    if (v) m_gray = x ^ (x >> 1);
    m_valid = v;
    m_err   = ChkEn && v && (x >= 4'd10);
    if (m_err) m_sticky = 1'b1;
    else if (ChkEn && clr) m_sticky = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_gray = 4'b0000; m_valid = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
  endtask

  // Expected Gray values for the BCD sweep 0..9.
  logic [3:0] gray_tab [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};

  initial begin
    logic [3:0] x;
    // Reset with the clock running.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #3 rst = 1'b0;

    // Full BCD sweep, back-to-back.
    for (int i = 0; i < 10; i++) begin
      step(4'(i), 1'b1, 1'b0, "sweep");
      check_eq("sweep.table", {4'b0, e, f, g, h}, {4'b0, gray_tab[i]});
    end

    // Hold: after one accepted digit, the output holds while in_valid is low.
    step(4'b0111, 1'b1, 1'b0, "hold.load");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0, "hold.idle");
    check_eq("hold.value", {4'b0, e, f, g, h}, 8'b0000_0100);

    // Invalid codes.
    step(4'b1010, 1'b1, 1'b0, "inv.1010");
    check_eq("inv.1010.gray", {4'b0, e, f, g, h}, 8'b0000_1111);
    step(4'b0000, 1'b0, 1'b0, "inv.after");
    step(4'b1111, 1'b1, 1'b0, "inv.1111");
    check_eq("inv.1111.gray", {4'b0, e, f, g, h}, 8'b0000_1000);

    // Sticky clear alone, then set and clear on the same edge.
    step(4'b0000, 1'b0, 1'b1, "clr.alone");
    step(4'b1011, 1'b1, 1'b0, "clr.reset");
    step(4'b1100, 1'b1, 1'b1, "clr.collide");
    check_eq("clr.collide.gray", {4'b0, e, f, g, h}, 8'b0000_1010);

    // Full 4-bit sweep (exercises 1010..1111 in both builds).
    for (int i = 0; i < 16; i++) step(4'(i), 1'b1, 1'b0, "sweep16");

    // Asynchronous reset mid-cycle with non-zero outputs.
    step(4'b1000, 1'b1, 1'b0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    // Inputs presented during reset must not produce out_valid later.
    {a, b, c, d} = 4'b0101;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("in_rst");
    in_valid = 1'b0;
    #2 rst = 1'b0;
    step(4'b0000, 1'b0, 1'b0, "post_rst");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      x = 4'($urandom_range(0, 15));
      step(x, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
